multi_sum_acc: RTL

//   Parametrised sequential adder for neuron pre-activation sums: adds N_IN

---
 rtl/multi_sum_acc.sv | 117 +++++++++++
 1 files changed

// File: rtl/multi_sum_acc.sv
// Sequential N_IN-word adder with bias for neuron pre-activation sums.
// One addition per cycle in a wide accumulator, then saturate/wrap to DATA_W.
module multi_sum_acc #(
  parameter int N_IN     = 4,
  parameter int DATA_W   = 32,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N_IN*DATA_W-1:0] in_flat,
  input  logic [DATA_W-1:0]      bias,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_W-1:0]      sum,
  output logic                   overflow
);

  localparam int ACC_W = DATA_W + $clog2(N_IN + 1);
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_W-1:0]         bank_q [N_IN];
  logic [DATA_W-1:0]         bank_d [N_IN];
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [DATA_W-1:0]         sum_q, sum_d;
  logic                      ovf_q, ovf_d;

  function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] w);
    if (SIGNED != 0) return {{(ACC_W-DATA_W){w[DATA_W-1]}}, w};
    else             return {{(ACC_W-DATA_W){1'b0}}, w};
  endfunction

  // Signed: all bits from DATA_W-1 upward must agree; unsigned: no bits above DATA_W-1.
  function automatic logic out_of_range(input logic signed [ACC_W-1:0] a);
    if (SIGNED != 0) return !((&a[ACC_W-1:DATA_W-1]) || !(|a[ACC_W-1:DATA_W-1]));
    else             return |a[ACC_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    if ((SATURATE != 0) && out_of_range(a)) begin
      if (SIGNED != 0) return a[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else             return {DATA_W{1'b1}};
    end
    return a[DATA_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    bank_d  = bank_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < N_IN; i++) bank_d[i] = in_flat[i*DATA_W +: DATA_W];
          acc_d   = ext(bias);
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + ext(bank_q[idx_q]);
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) state_d = FINISH;
      end
      FINISH: begin
        sum_d   = sat(acc_q);
        ovf_d   = out_of_range(acc_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < N_IN; i++) bank_q[i] <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      for (int i = 0; i < N_IN; i++) bank_q[i] <= bank_d[i];
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign overflow = ovf_q;

endmodule
